// File: rtl/p_inverse_transformation_pkg.sv
// Shared definitions for the P-transformation blocks: FSM state encoding,
// default key and key digit extraction.
package p_inverse_transformation_pkg;

  // Byte-processing states of the inverse transformation
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Key after reset: digits k3..k0 = 2,1,0,3
  localparam logic [7:0] KEY_DEFAULT = 8'b10_01_00_11;

  // Digit j of a key: bits [2j+1:2j]
  function automatic logic [1:0] key_digit(input logic [7:0] key, input logic [1:0] j);
    return key[{j, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/p_inverse_transformation_key_check.sv
// Combinational key checker: a key is usable only when its four 2-bit
// digits form a permutation of {0,1,2,3}. Also used by the forward block.
module p_key_check
  import p_inverse_transformation_pkg::*;
(
  input  logic [7:0] key,
  output logic       valid
);

  logic [1:0] d0, d1, d2, d3;

  assign d0 = key_digit(key, 2'd0);
  assign d1 = key_digit(key, 2'd1);
  assign d2 = key_digit(key, 2'd2);
  assign d3 = key_digit(key, 2'd3);

  // Four digits drawn from four values are a permutation iff all are distinct
  assign valid = (d0 != d1) && (d0 != d2) && (d0 != d3) &&
                 (d1 != d2) && (d1 != d3) &&
                 (d2 != d3);

endmodule

// File: rtl/p_inverse_transformation.sv
// Inverse keyed P-transformation: accepts a permuted byte Y and rebuilds the
// original byte X one bit pair per clock, with valid/ready on both sides and
// a runtime-loadable key.
module p_inverse_transformation
  import p_inverse_transformation_pkg::*;
#(
  parameter logic [7:0] KEY_INIT = KEY_DEFAULT
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [7:0] In,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] key_in,
  input  logic       key_load,
  output logic       key_err,
  output logic [7:0] Out,
  output logic       out_valid,
  input  logic       out_ready
);

  state_t     state;
  state_t     state_next;
  logic [1:0] j;
  logic [1:0] digit;
  logic [7:0] y_reg;
  logic [7:0] work;
  logic [7:0] work_next;
  logic [7:0] out_reg;
  logic [7:0] key_reg;
  logic       key_err_reg;
  logic       key_in_ok;
  logic       key_load_ok;
  logic       accept;
  logic       last_pair;

  p_key_check u_key_check (
    .key   (key_in),
    .valid (key_in_ok)
  );

  // A key load is honoured only between bytes, so the key is fixed in flight
  assign key_load_ok = key_load & (state == IDLE);
  // key_load has priority over an incoming byte in the same cycle
  assign in_ready    = (state == IDLE) & ~key_err_reg & ~key_load;
  assign accept      = in_valid & in_ready;
  assign last_pair   = (j == 2'd3);
  assign digit       = key_digit(key_reg, j);

  assign out_valid = (state == DONE);
  assign Out       = out_reg;
  assign key_err   = key_err_reg;

  // Work register with the current bit pair scattered back to positions k_j and k_j+4
  // NOTE: every variable written here gets a full default first, so no latch is inferred.
  always_comb begin
    work_next = work;
    work_next[{1'b0, digit}] = y_reg[{j, 1'b1}];
    work_next[{1'b1, digit}] = y_reg[{j, 1'b0}];
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)    state_next = SHIFT;
      SHIFT:   if (last_pair) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // State register
  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge Clk) begin
    if (Rst) state <= IDLE;
    else     state <= state_next;
  end

  // Datapath: latch Y, walk the four bit pairs, capture the finished byte
  // NOTE: the datapath registers are reset too, so Out reads 8'h00 and no stale byte survives an abort.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      j       <= 2'd0;
      y_reg   <= 8'h00;
      work    <= 8'h00;
      out_reg <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            y_reg <= In;
            work  <= 8'h00;
            j     <= 2'd0;
          end
        end
        SHIFT: begin
          work <= work_next;
          j    <= j + 2'd1;
          if (last_pair) out_reg <= work_next;
        end
        default: ;
      endcase
    end
  end

  // Key register and its validity flag, updated together on an honoured load
  always_ff @(posedge Clk) begin
    if (Rst) begin
      key_reg     <= KEY_INIT;
      key_err_reg <= 1'b0;
    end else if (key_load_ok) begin
      key_reg     <= key_in;
      key_err_reg <= ~key_in_ok;
    end
  end

endmodule
